// File: rtl/stos_powrotu_if.sv
// Bus bundle for the return-address stack: control/data from the decoder
// (master) and stack status back from the stack (slave).
interface stos_powrotu_if #(
    parameter int W     = 8,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          flush;
    logic          push;
    logic          pop;
    logic [W-1:0]  push_data;
    logic          push_int;
    logic          clr_err;
    logic [W-1:0]  top;
    logic          top_int;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;

    modport master (
        output flush, push, pop, push_data, push_int, clr_err,
        input  top, top_int, level, empty, full, ovf, unf
    );

    modport slave (
        input  flush, push, pop, push_data, push_int, clr_err,
        output top, top_int, level, empty, full, ovf, unf
    );
endinterface

// File: rtl/stos_powrotu.sv
// stos_powrotu: hardware return-address stack (LIFO) with sticky overflow/underflow flags.
// Optional feature: define STOS_INT_EN to store an interrupt-frame marker with every entry.
module stos_powrotu #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input logic           clk,
    input logic           rst,
    stos_powrotu_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
`ifdef STOS_INT_EN
    localparam int EW = W + 1;
`else
    localparam int EW = W;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [LW-1:0] level_q;
    logic          ovf_q;
    logic          unf_q;

    logic [LW-1:0] top_ptr;
    logic          is_empty;
    logic          is_full;
    logic          do_push;
    logic          do_replace;
    logic          do_pop;
    logic          ovf_evt;
    logic          unf_evt;
    logic [AW-1:0] wr_idx;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] top_entry;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LW'(DEPTH));
    assign top_ptr  = level_q - LW'(1);

    // Push+pop on an empty stack falls through to the plain-push branch, so it never flags underflow.
    always_comb begin
        do_push    = 1'b0;
        do_replace = 1'b0;
        do_pop     = 1'b0;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (!bus.flush) begin
            if (bus.push && bus.pop && !is_empty) begin
                do_replace = 1'b1;
            end else if (bus.push) begin
                if (is_full) ovf_evt = 1'b1;
                else         do_push = 1'b1;
            end else if (bus.pop) begin
                if (is_empty) unf_evt = 1'b1;
                else          do_pop  = 1'b1;
            end
        end
    end

    assign wr_idx = do_replace ? top_ptr[AW-1:0] : level_q[AW-1:0];

`ifdef STOS_INT_EN
    assign wr_entry = {bus.push_int, bus.push_data};
`else
    logic unused_push_int;
    assign unused_push_int = bus.push_int;
    assign wr_entry        = bus.push_data;
`endif

    // Storage is not reset; emptiness masking on the read side keeps stale data invisible.
    always_ff @(posedge clk) begin
        if (do_push || do_replace) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (bus.flush)   level_q <= '0;
            else if (do_push) level_q <= level_q + LW'(1);
            else if (do_pop)  level_q <= top_ptr;

            // A fresh error in the same cycle as clr_err keeps the flag set.
            if (ovf_evt)          ovf_q <= 1'b1;
            else if (bus.clr_err) ovf_q <= 1'b0;

            if (unf_evt)          unf_q <= 1'b1;
            else if (bus.clr_err) unf_q <= 1'b0;
        end
    end

    assign top_entry = is_empty ? '0 : mem[top_ptr[AW-1:0]];
    assign bus.top   = top_entry[W-1:0];
`ifdef STOS_INT_EN
    assign bus.top_int = top_entry[W];
`else
    assign bus.top_int = 1'b0;
`endif
    assign bus.level = level_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_stos_powrotu.sv
// Scoreboard bench for stos_powrotu: stimulus queues expected post-edge state,
// a monitor pops and compares it after every rising edge.
module tb_stos_powrotu;
    localparam int W     = 8;
    localparam int DEPTH = 8;
`ifdef STOS_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    typedef struct {
        string      nm;
        logic [7:0] top;
        int         level;
        logic       ovf;
        logic       unf;
        logic       ti;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    stos_powrotu_if #(.W(W), .DEPTH(DEPTH)) bus ();

    stos_powrotu #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input bit fl, input bit pu, input bit po,
                        input logic [7:0] d, input bit pi, input bit ce,
                        input logic [7:0] et, input int el, input bit eo, input bit eu,
                        input bit ei);
        exp_t e;
        @(negedge clk);
        bus.flush     = fl;
        bus.push      = pu;
        bus.pop       = po;
        bus.push_data = d;
        bus.push_int  = pi;
        bus.clr_err   = ce;
        e.nm = nm; e.top = et; e.level = el; e.ovf = eo; e.unf = eu; e.ti = INT_EN & ei;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.flush = 0; bus.push = 0; bus.pop = 0; bus.push_int = 0; bus.clr_err = 0;
        bus.push_data = '0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.nm, ".top"},     32'(bus.top),     32'(e.top));
            chk({e.nm, ".level"},   32'(bus.level),   32'(e.level));
            chk({e.nm, ".empty"},   32'(bus.empty),   32'(e.level == 0));
            chk({e.nm, ".full"},    32'(bus.full),    32'(e.level == DEPTH));
            chk({e.nm, ".ovf"},     32'(bus.ovf),     32'(e.ovf));
            chk({e.nm, ".unf"},     32'(bus.unf),     32'(e.unf));
            chk({e.nm, ".top_int"}, 32'(bus.top_int), 32'(e.ti));
        end
    end

    task automatic check_reset_state(input string nm);
        chk({nm, ".level"},   32'(bus.level),   32'd0);
        chk({nm, ".empty"},   32'(bus.empty),   32'd1);
        chk({nm, ".full"},    32'(bus.full),    32'd0);
        chk({nm, ".ovf"},     32'(bus.ovf),     32'd0);
        chk({nm, ".unf"},     32'(bus.unf),     32'd0);
        chk({nm, ".top"},     32'(bus.top),     32'd0);
        chk({nm, ".top_int"}, 32'(bus.top_int), 32'd0);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        chk({nm, ".queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 0; bus.push = 0; bus.pop = 0; bus.push_int = 0; bus.clr_err = 0;
        bus.push_data = '0;
        #1;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // basic push/pop sequence
        step("push12", 0,1,0,8'h12,0,0, 8'h12,1,0,0,0);
        step("push34", 0,1,0,8'h34,0,0, 8'h34,2,0,0,0);
        step("push56", 0,1,0,8'h56,0,0, 8'h56,3,0,0,0);
        step("pop1",   0,0,1,8'h00,0,0, 8'h34,2,0,0,0);
        step("pop2",   0,0,1,8'h00,0,0, 8'h12,1,0,0,0);
        step("pop3",   0,0,1,8'h00,0,0, 8'h00,0,0,0,0);

        // fill to full, overflow, error clearing, replace while full
        for (int i = 1; i <= 8; i++)
            step($sformatf("fill%0d", i), 0,1,0,8'(i),0,0, 8'(i),i,0,0,0);
        step("ovf_push9",   0,1,0,8'h09,0,0, 8'h08,8,1,0,0);
        step("clr_ovf",     0,0,0,8'h00,0,1, 8'h08,8,0,0,0);
        step("ovf_vs_clr",  0,1,0,8'h0A,0,1, 8'h08,8,1,0,0);
        step("clr_ovf2",    0,0,0,8'h00,0,1, 8'h08,8,0,0,0);
        step("repl_full",   0,1,1,8'h99,0,0, 8'h99,8,0,0,0);
        step("flush_full",  1,0,0,8'h00,0,0, 8'h00,0,0,0,0);

        // underflow, replace-top, push+pop on empty
        step("unf_pop",     0,0,1,8'h00,0,0, 8'h00,0,0,1,0);
        step("push10",      0,1,0,8'h10,0,0, 8'h10,1,0,1,0);
        step("push20",      0,1,0,8'h20,0,0, 8'h20,2,0,1,0);
        step("repl77",      0,1,1,8'h77,0,0, 8'h77,2,0,1,0);
        step("pop_after_r", 0,0,1,8'h00,0,0, 8'h10,1,0,1,0);
        step("clr_unf",     0,0,0,8'h00,0,1, 8'h10,1,0,0,0);
        step("flush1",      1,0,0,8'h00,0,0, 8'h00,0,0,0,0);
        step("pushpop_emp", 0,1,1,8'h33,0,0, 8'h33,1,0,0,0);

        // flush beats push, then entry[0] is reused
        step("push44",      0,1,0,8'h44,0,0, 8'h44,2,0,0,0);
        step("push55",      0,1,0,8'h55,0,0, 8'h55,3,0,0,0);
        step("flush_push",  1,1,0,8'hAA,0,0, 8'h00,0,0,0,0);
        step("push05",      0,1,0,8'h05,0,0, 8'h05,1,0,0,0);
        step("pop05",       0,0,1,8'h00,0,0, 8'h00,0,0,0,0);
        step("unf2",        0,0,1,8'h00,0,0, 8'h00,0,0,1,0);
        step("flush_keep",  1,0,0,8'h00,0,0, 8'h00,0,0,1,0);
        step("clr_unf2",    0,0,0,8'h00,0,1, 8'h00,0,0,0,0);

        // interrupt-frame marker
        step("push40i",     0,1,0,8'h40,1,0, 8'h40,1,0,0,1);
        step("push41",      0,1,0,8'h41,0,0, 8'h41,2,0,0,0);
        step("pop_to40",    0,0,1,8'h00,0,0, 8'h40,1,0,0,1);
        step("pop_int_emp", 0,0,1,8'h00,0,0, 8'h00,0,0,0,0);

        // build level=4 with ovf=1 for the async reset test
        for (int i = 1; i <= 8; i++)
            step($sformatf("refill%0d", i), 0,1,0,8'(8'h80 + i),0,0, 8'(8'h80 + i),i,0,0,0);
        step("ovf_again", 0,1,0,8'hFF,0,0, 8'h88,8,1,0,0);
        for (int i = 1; i <= 4; i++)
            step($sformatf("down%0d", i), 0,0,1,8'h00,0,0, 8'(8'h88 - i),8-i,1,0,0);
        idle();
        drain("pre_rst");

        #2 rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        rst = 1'b0;

        step("post_rst_push", 0,1,0,8'h5A,0,0, 8'h5A,1,0,0,0);
        step("post_rst_pop",  0,0,1,8'h00,0,0, 8'h00,0,0,0,0);
        idle();
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
